mio_bus_ctrl: RTL
=================

Name: mio_bus_ctrl

Overview:
- Parametrised memory/IO bus controller between the multi-cycle CPU's MIO port (CPU_MIO, mem_w, Addr_out, Data_out, Data_in, MIO_ready) and N_CH peripheral channels (RAM, ROM, GPIO, ...).
- Decodes each CPU access to one channel and runs a four-phase handshake with the CPU.
- Tolerates variable-latency slaves; converts missing acks and unmapped addresses into a bus error.

Parameters:
- N_CH, 4, number of peripheral channels (1..16).
- DW, 32, data width.
- AW, 32, address width.
- SEL_LSB, 28, lowest address bit of the channel-select field; field width CW = max(1, clog2(N_CH)).
- TIMEOUT, 15, maximum cycles spent waiting for a channel ack before a bus error (1..255).
- ERR_DATA, 32'hDEAD_BEEF, read data returned on error.

Ports:
- clk, in, 1: rising-edge clock.
- reset, in, 1: asynchronous, active-low reset.
- CPU_MIO, in, 1: CPU access request; held high until MIO_ready is seen.
- mem_w, in, 1: 1 = write, 0 = read; valid while CPU_MIO = 1.
- Addr_out, in, AW: CPU address.
- Data_out, in, DW: CPU write data.
- Data_in, out, DW: read data to the CPU; valid while MIO_ready = 1.
- MIO_ready, out, 1: access complete.
- bus_err, out, 1: current completion is an error; valid with MIO_ready.
- ch_req, out, N_CH: one-hot channel request.
- ch_we, out, 1: write strobe qualifier, shared by all channels.
- ch_addr, out, AW: registered address, shared.
- ch_wdata, out, DW: registered write data, shared.
- ch_rdata, in, N_CH*DW: channel read data; channel i occupies bits [i*DW +: DW].
- ch_ack, in, N_CH: per-channel completion pulse.
- err_cnt, out, 8: saturating count of bus errors.

Behaviour:
- Reset (reset = 0, asynchronous): state = IDLE.
  - All outputs are 0: ch_req, ch_we, ch_addr, ch_wdata, Data_in, MIO_ready, bus_err, err_cnt.
  - The timeout counter is 0.
- FSM states: IDLE, REQ, HOLD.
- IDLE:
  - On CPU_MIO = 1, register Addr_out, Data_out and mem_w into ch_addr, ch_wdata and ch_we.
  - Compute sel = Addr_out[SEL_LSB +: CW].
  - If sel < N_CH: set ch_req[sel] = 1, clear the counter, go to REQ.
  - If sel >= N_CH (unmapped): Data_in = ERR_DATA, bus_err = 1, MIO_ready = 1, err_cnt++, go to HOLD. No ch_req is asserted.
- REQ:
  - ch_req stays asserted every cycle.
  - ch_ack is checked only on the selected channel; acks on other channels are ignored.
  - If ch_ack[sel] = 1: drop ch_req. For a read, Data_in = the sel slice of ch_rdata; for a write, Data_in = 0. Set bus_err = 0, MIO_ready = 1, go to HOLD.
  - Else, if counter == TIMEOUT-1: drop ch_req, Data_in = ERR_DATA, bus_err = 1, MIO_ready = 1, err_cnt++, go to HOLD.
  - Else: counter++.
  - An ack arriving in the same cycle as the timeout threshold wins; the access completes normally.
- HOLD:
  - MIO_ready, Data_in and bus_err are held stable.
  - When CPU_MIO = 0: clear MIO_ready and bus_err, go to IDLE.
  - While in HOLD, CPU_MIO = 1 never starts a new access (no double issue).
- Latency, CPU_MIO rise to MIO_ready rise:
  - Zero-wait slave (ack in the first REQ cycle): 2 cycles.
  - General case: 2 + slave wait cycles.
  - Timeout: TIMEOUT+1 cycles.
  - Unmapped address: 1 cycle.
- Throughput: one access per 3 cycles minimum; the CPU must drop CPU_MIO for at least one cycle between accesses.
- Inputs are ignored outside the rules above. Changes to Addr_out, Data_out or mem_w after the IDLE capture have no effect.
- err_cnt saturates at 255 and never wraps.
- Reset during REQ: ch_req drops immediately (asynchronous), and any late ack after reset release is ignored because the FSM is in IDLE.
- N_CH = 1: CW = 1, so addresses with select bit 1 are unmapped.

Decomposition:
- Shared package mio_pkg:
  - FSM state enum (IDLE, REQ, HOLD).
  - ERR_DATA default.
  - clog2 function.
- Sub-module mio_timeout_cnt:
  - Loadable counter, width clog2(TIMEOUT+1).
  - Inputs: clear, enable. Output: expired.
- Read-data mux and address decode stay inline.

Test Plan:
- Read, zero-wait: Addr_out=32'h0000_0010, mem_w=0; ch0 acks in the first REQ cycle with rdata 32'h2008_03E0 -> ch_req=4'b0001 for 1 cycle; MIO_ready high 2 cycles after CPU_MIO rise; Data_in=32'h2008_03E0; bus_err=0.
- Write with wait states: Addr_out=32'h1000_0004, Data_out=32'hAD09_0000, mem_w=1; ch1 acks after 3 wait cycles -> ch_req=4'b0010 with ch_we=1 and ch_wdata=32'hAD09_0000 for 4 cycles; MIO_ready 5 cycles after CPU_MIO rise; Data_in=0.
- Timeout: access to ch2, no ack ever -> ch_req drops after 15 cycles; MIO_ready with Data_in=32'hDEAD_BEEF and bus_err=1; err_cnt=1.
- Unmapped address: N_CH=3, Addr_out=32'h3000_0000 -> no ch_req; MIO_ready the next cycle with bus_err=1; a late ch_ack[3] (N_CH=4 build) is ignored.
- Handshake: hold CPU_MIO high for 6 cycles after MIO_ready -> single ch_req pulse train only; MIO_ready falls the cycle after CPU_MIO drops; ack coinciding with the timeout threshold -> normal data, bus_err=0.
- Reset mid-REQ: assert reset=0 while ch_req=4'b0100 -> all outputs 0 immediately; after release, an ack on ch2 produces no MIO_ready; 300 forced errors -> err_cnt=255.

Source files
------------

// File: rtl/mio_pkg.sv
// Shared definitions for the MIO bus controller slice.
//   mio_state_t  : controller FSM states
//   ERR_DATA_DEF : read data returned on a bus error
//   clog2        : ceiling log2 for parameter arithmetic (clog2(1) = 0)
package mio_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } mio_state_t;

  localparam logic [31:0] ERR_DATA_DEF = 32'hDEAD_BEEF;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/mio_timeout_cnt.sv
// Ack-wait timeout counter.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : reload the count to zero
//   enable     : advance the count by one
//   expired    : count has reached TIMEOUT-1 (last permitted wait cycle)
module mio_timeout_cnt
  import mio_pkg::*;
#(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CNTW = (clog2(TIMEOUT + 1) < 1) ? 1 : clog2(TIMEOUT + 1);

  logic [CNTW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      cnt <= '0;
    else if (clear)  cnt <= '0;
    else if (enable) cnt <= cnt + 1'b1;
  end

  assign expired = (cnt == CNTW'(TIMEOUT - 1));

endmodule

// File: rtl/mio_bus_ctrl.sv
// Memory/IO bus controller between the CPU MIO port and N_CH slave channels.
//   clk, reset            : clock, asynchronous active-low reset
//   CPU_MIO, mem_w        : CPU request and direction (1 = write)
//   Addr_out, Data_out    : CPU address and write data
//   Data_in, MIO_ready    : read data and completion back to the CPU
//   bus_err               : completion is an error (timeout or unmapped)
//   ch_req, ch_we         : one-hot channel request, shared write qualifier
//   ch_addr, ch_wdata     : registered address / write data, shared
//   ch_rdata, ch_ack      : packed channel read data, per-channel ack
//   err_cnt               : saturating bus error count
module mio_bus_ctrl
  import mio_pkg::*;
#(
  parameter int unsigned   N_CH     = 4,
  parameter int unsigned   DW       = 32,
  parameter int unsigned   AW       = 32,
  parameter int unsigned   SEL_LSB  = 28,
  parameter int unsigned   TIMEOUT  = 15,
  parameter logic [DW-1:0] ERR_DATA = DW'(ERR_DATA_DEF)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               CPU_MIO,
  input  logic               mem_w,
  input  logic [AW-1:0]      Addr_out,
  input  logic [DW-1:0]      Data_out,
  output logic [DW-1:0]      Data_in,
  output logic               MIO_ready,
  output logic               bus_err,
  output logic [N_CH-1:0]    ch_req,
  output logic               ch_we,
  output logic [AW-1:0]      ch_addr,
  output logic [DW-1:0]      ch_wdata,
  input  logic [N_CH*DW-1:0] ch_rdata,
  input  logic [N_CH-1:0]    ch_ack,
  output logic [7:0]         err_cnt
);

  localparam int unsigned CW = (clog2(N_CH) < 1) ? 1 : clog2(N_CH);

  mio_state_t state, state_nxt;

  logic [N_CH-1:0] req_nxt;
  logic            we_nxt;
  logic [AW-1:0]   addr_nxt;
  logic [DW-1:0]   wdata_nxt;
  logic [DW-1:0]   data_nxt;
  logic            rdy_nxt;
  logic            err_nxt;
  logic [7:0]      cnt_nxt;
  logic [7:0]      err_inc;

  logic [CW-1:0]   sel_in, sel_q;
  logic [N_CH-1:0] sel_onehot;
  logic            sel_ok;
  logic            ack_sel;
  logic [DW-1:0]   rdata_sel;

  logic tmo_clr, tmo_en, tmo_expired;

  mio_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_tmo (
    .clk     (clk),
    .rst_n   (reset),
    .clear   (tmo_clr),
    .enable  (tmo_en),
    .expired (tmo_expired)
  );

  assign sel_in  = Addr_out[SEL_LSB +: CW];
  assign sel_q   = ch_addr[SEL_LSB +: CW];
  assign err_inc = (err_cnt == '1) ? err_cnt : err_cnt + 8'd1;

  // Decode and muxes by comparison loop; a select value with no matching
  // channel yields an all-zero one-hot, which doubles as the unmapped test.
  always_comb begin
    sel_onehot = '0;
    ack_sel    = 1'b0;
    rdata_sel  = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      sel_onehot[i] = (sel_in == CW'(i));
      if (sel_q == CW'(i)) begin
        ack_sel   = ch_ack[i];
        rdata_sel = ch_rdata[i*DW +: DW];
      end
    end
    sel_ok = |sel_onehot;
  end

  always_comb begin
    state_nxt = state;
    req_nxt   = ch_req;
    we_nxt    = ch_we;
    addr_nxt  = ch_addr;
    wdata_nxt = ch_wdata;
    data_nxt  = Data_in;
    rdy_nxt   = MIO_ready;
    err_nxt   = bus_err;
    cnt_nxt   = err_cnt;
    tmo_clr   = 1'b0;
    tmo_en    = 1'b0;
    case (state)
      IDLE: begin
        if (CPU_MIO) begin
          addr_nxt  = Addr_out;
          wdata_nxt = Data_out;
          we_nxt    = mem_w;
          if (sel_ok) begin
            req_nxt   = sel_onehot;
            tmo_clr   = 1'b1;
            state_nxt = REQ;
          end else begin
            data_nxt  = ERR_DATA;
            err_nxt   = 1'b1;
            rdy_nxt   = 1'b1;
            cnt_nxt   = err_inc;
            state_nxt = HOLD;
          end
        end
      end
      REQ: begin
        // Ack is tested before the timeout so a coincident ack wins.
        if (ack_sel) begin
          req_nxt   = '0;
          data_nxt  = ch_we ? '0 : rdata_sel;
          err_nxt   = 1'b0;
          rdy_nxt   = 1'b1;
          state_nxt = HOLD;
        end else if (tmo_expired) begin
          req_nxt   = '0;
          data_nxt  = ERR_DATA;
          err_nxt   = 1'b1;
          rdy_nxt   = 1'b1;
          cnt_nxt   = err_inc;
          state_nxt = HOLD;
        end else begin
          tmo_en = 1'b1;
        end
      end
      HOLD: begin
        if (!CPU_MIO) begin
          rdy_nxt   = 1'b0;
          err_nxt   = 1'b0;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      ch_req    <= '0;
      ch_we     <= 1'b0;
      ch_addr   <= '0;
      ch_wdata  <= '0;
      Data_in   <= '0;
      MIO_ready <= 1'b0;
      bus_err   <= 1'b0;
      err_cnt   <= '0;
    end else begin
      state     <= state_nxt;
      ch_req    <= req_nxt;
      ch_we     <= we_nxt;
      ch_addr   <= addr_nxt;
      ch_wdata  <= wdata_nxt;
      Data_in   <= data_nxt;
      MIO_ready <= rdy_nxt;
      bus_err   <= err_nxt;
      err_cnt   <= cnt_nxt;
    end
  end

endmodule
